uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning tick16 pulses per bit period (range 2..64).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per frame (1 or 2).
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick16  input  1  single-cycle enable at 16x baud (153600 Hz for 9600 baud), synchronous to clk.
REQ-006 SHALL have port tx_data  input  8  byte to send, LSB first.
REQ-007 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-008 SHALL have port tx_ready  output  1  block can accept a byte.
REQ-009 SHALL have port tx  output  1  serial line; idle high.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port tx_done  output  1  single-cycle pulse at end of frame.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transitions IDLE->START->DATA->(PARITY)->STOP->IDLE.
REQ-013 SHALL accept a byte when tx_valid && tx_ready at a clk rising edge; latch tx_data into a shift register at that edge only.
REQ-014 SHALL deassert tx_ready and assert busy from the cycle after acceptance until the frame ends.
REQ-015 SHALL drive tx low (start bit) from the cycle after acceptance.
REQ-016 SHALL end each bit period on the OVERSAMPLE-th tick16 pulse counted after that bit began; a tick16 in the acceptance cycle is not counted.
REQ-017 SHALL drive data bits 0..7 LSB first, one per bit period, using a 3-bit bit index and a tick counter of width ceil(log2(OVERSAMPLE)).
REQ-018 SHALL drive tx high for STOP_BITS bit periods in STOP.
REQ-019 SHALL, on the final tick of STOP, pulse tx_done for one cycle, return to IDLE, and assert tx_ready and deassert busy in the next cycle.
REQ-020 SHALL ignore tx_valid and tx_data changes while busy; no queuing.
REQ-021 SHALL, when tx_valid is held high continuously, accept the next byte in the first cycle tx_ready is high, so tx_ready is high for exactly one cycle between frames.
REQ-022 SHALL register tx (no combinational path from inputs to tx).
REQ-023 SHALL never glitch tx within a bit period; tx changes only at state or bit boundaries.

Reset
REQ-024 SHALL, on rst_n low, immediately force state IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, and clear the counters and shift register, irrespective of clk.
REQ-025 SHALL, on rst_n low mid-frame, abandon the frame without emitting tx_done; first acceptance possible in the first clk edge after rst_n rises.

Configuration
REQ-026 SHALL, with macro UART_TX_PARITY_EN defined, insert one even-parity bit (XOR of the 8 data bits) for one bit period in state PARITY between DATA and STOP.
REQ-027 SHALL, without UART_TX_PARITY_EN, omit state PARITY so that DATA proceeds directly to STOP; frame = 10 bits for STOP_BITS=1.

Verification
REQ-028 SHALL cover: tick16 every 4 clks, OVERSAMPLE=16, send 0x55, no parity -> tx = 0,1,0,1,0,1,0,1,0,1 with each bit lasting 64 clks; tx_done after 640 clks; tx_ready high again the next cycle.
REQ-029 SHALL cover: UART_TX_PARITY_EN defined, send 0xA5 then 0x07 -> parity bit 0 for 0xA5 and 1 for 0x07; 11-bit frames.
REQ-030 SHALL cover: tx_valid held high with data 0x12 then 0x34 -> two back-to-back frames; tx_ready high for exactly 1 cycle between them; second frame carries 0x34.
REQ-031 SHALL cover: rst_n pulled low during data bit 3 of 0xFF -> tx=1, busy=0, tx_ready=1 immediately; no tx_done; next send of 0x81 is correct.
REQ-032 SHALL cover: tx_data changed from 0x3C to 0xC3 and tx_valid pulsed while busy -> the transmitted byte stays 0x3C; the second request is dropped.
REQ-033 SHALL cover: STOP_BITS=2, send 0x00 -> tx low for 9 bit periods, then high for 2 bit periods before tx_done.

Source files
------------

// File: rtl/uart_tx.sv
// Purpose: 8N1/8E1 UART transmitter, LSB first, STOP_BITS stop bits, paced by a tick16 enable.
// Latency: start bit driven the cycle after acceptance; each bit lasts OVERSAMPLE tick16 pulses.
// Backpressure: tx_ready is high only in IDLE; requests while busy are dropped, never queued.
//
// Ports:
//   clk       system clock (only clock)
//   rst_n     asynchronous active-low reset
//   tick16    single-cycle bit-rate enable, OVERSAMPLE pulses per bit
//   tx_data   byte to send, latched on the accepting edge
//   tx_valid  send request
//   tx_ready  block can accept a byte this cycle
//   tx        registered serial line, idle high
//   busy      frame in progress
//   tx_done   one-cycle pulse, coincides with the first cycle of tx_ready after a frame
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick16,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;    // data bit index in DATA, stop bit index in STOP
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            bit_end;

`ifdef UART_TX_PARITY_EN
  // Parity is captured at acceptance because the shift register is consumed during DATA.
  logic            par_q, par_d;
`endif

  // A bit period ends on the OVERSAMPLE-th tick counted since that bit began.
  assign bit_end = tick16 && (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Ticks are only counted inside a frame, so a tick in the accepting cycle is ignored.
    if (state_q != IDLE && tick16) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = START;
          shreg_d = tx_data;
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          // The next bit is shreg_q[1] because shreg_q[0] is the bit now on the line.
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;  // wraps to 0 after bit 7, ready to count stop bits
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

endmodule
